audio_rx_fifo: RTL and testbench
================================

Name: audio_rx_fifo

Overview:
- Parametrised multi-channel audio receiver: captures NUM_CH packed samples of IN_W bits on each falling edge of the transmitter ready line (rx_ready).
- Widens each sample to OUT_W bits per a runtime fill mode and buffers whole frames in a DEPTH-entry FIFO.
- Delivers frames downstream with a valid/ready handshake.
- Sits between the link/transmitter interface and the audio codec/DSP path.

Parameters:
- NUM_CH, 2, number of audio channels per frame.
- IN_W, 12, input sample width per channel.
- OUT_W, 18, output sample width per channel; must be >= IN_W.
- DEPTH, 8, FIFO depth in frames; power of two, >= 2.

Ports:
- clock_in  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rx_ready  in  1  transmitter ready; asynchronous to clock_in; a falling edge marks a new frame.
- audio_in  in  NUM_CH*IN_W  packed input samples; channel 0 in the LSBs.
- fill_mode  in  2  low-bit fill: 00 zero, 01 sign-replicate, 10 mute, 11 treated as 00.
- out_ready  in  1  downstream accepts a frame.
- ovf_clear  in  1  single-cycle pulse; clears overflow.
- audio_out  out  NUM_CH*OUT_W  packed widened samples at the FIFO head.
- out_valid  out  1  audio_out holds a valid frame.
- level  out  $clog2(DEPTH)+1  frames currently stored.
- overflow  out  1  sticky: a frame was dropped.

Behaviour:
- Reset (reset low, asynchronous): pointers, level, overflow and out_valid = 0; audio_out = 0; synchronizer flops = 1, so no false edge on release.
- Edge capture:
  - rx_ready passes through 3 flops s1→s2→s3; fall = s3 & ~s2.
  - A frame write occurs on the clock edge where fall = 1; audio_in and fill_mode are sampled at that edge.
  - audio_in must be stable for >= 4 clock_in cycles after rx_ready falls.
- Widening per channel c, applied at write and stored as OUT_W bits:
  - zero: {in_c, (OUT_W-IN_W) zeros}.
  - sign-replicate: {in_c, (OUT_W-IN_W) copies of in_c[IN_W-1]}.
  - mute: all zeros.
  - If OUT_W == IN_W, the sample passes unchanged in every mode except mute.
- FIFO:
  - Show-ahead; audio_out is the registered head entry.
  - out_valid = (level != 0).
  - Pop when out_valid & out_ready.
  - Latency: rx_ready falling → write edge is 3 clock_in cycles; out_valid rises the cycle after the write when the FIFO was empty.
- Pointers are ADDR_W+1 bits (ADDR_W = log2 DEPTH) and wrap naturally.
- Simultaneous write and pop:
  - level unchanged; both operations happen.
  - When full, the pop frees the slot, so the write is accepted with no overflow.
  - When empty, no pop occurs (out_valid = 0); only the write happens.
- Full with a write and no pop: the frame is dropped, overflow is set, and stored data is untouched.
- Overflow clears only on ovf_clear. If set and clear occur in the same cycle, set wins.
- Empty with out_ready high: no effect; audio_out holds its last value.
- A fill_mode change affects only subsequent writes.
- Reset mid-stream discards all buffered frames immediately.

Optional Feature:
- Macro: AUDIO_RX_PEAK_EN.
- Enabled:
  - Adds output peak [NUM_CH*IN_W-1:0]: per-channel max |in_c| over written frames (two's complement magnitude, -2^(IN_W-1) saturates to 2^(IN_W-1)-1).
  - Adds input peak_clear, which zeroes peak; a write in the same cycle loads that frame's magnitude.
  - peak resets to 0.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package audio_rx_pkg holds the fill-mode constants (FILL_ZERO = 2'b00, FILL_SIGN = 2'b01, FILL_MUTE = 2'b10) and a widen function (in_c, mode) → OUT_W bits.
- One sub-module, audio_rx_sync_fall: the 3-flop synchronizer plus falling-edge detect, with reset to 1.
- FIFO storage stays inline.

Test Plan:
- Defaults, mode 01, audio_in = {12'h800, 12'h7FF}; pulse rx_ready low → after 3 cycles the write occurs, and the next cycle gives out_valid = 1, audio_out = {18'h2003F, 18'h1FFC0}.
- Mode 00, same data → {18'h20000, 18'h1FFC0}; mode 10 → audio_out = 0; mode 11 matches mode 00.
- out_ready = 0, 9 frames → level = 8, overflow = 1, and the 9th frame is dropped. Then drain 8 with out_ready = 1 → frames 1..8 in order, out_valid falls after the 8th. Pulse ovf_clear → overflow = 0.
- FIFO full, and the write edge coincides with a pop → overflow stays 0, level stays 8, and the new frame appears last.
- Assert reset with level = 5 mid-stream → out_valid, level and audio_out = 0 asynchronously; no spurious write after release while rx_ready is high.
- AUDIO_RX_PEAK_EN: frames with ch0 = 12'h005, 12'hFF0, 12'h800 → peak ch0 = 12'h005, 12'h010, 12'h7FF; peak_clear → 0.

Source files
------------

// File: rtl/audio_rx_pkg.sv
// Shared definitions for the audio receive FIFO: fill-mode encodings and the
// per-channel sample widening function.
package audio_rx_pkg;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'b00,
    FILL_SIGN = 2'b01,
    FILL_MUTE = 2'b10,
    FILL_RSVD = 2'b11
  } fill_mode_e;

  localparam int MAX_W = 64;

  // Sample sits in the MSBs of the output word; the low (out_w-in_w) bits are
  // zero or copies of the sample sign. in_c must be zero above bit in_w-1.
  function automatic logic [MAX_W-1:0] widen(input logic [MAX_W-1:0] in_c,
                                             input logic [1:0]       mode,
                                             input int               in_w,
                                             input int               out_w);
    logic [MAX_W-1:0] low_mask;
    logic             sign;
    int               ext;
    ext      = out_w - in_w;
    low_mask = (MAX_W'(1) << ext) - MAX_W'(1);
    sign     = |(in_c & (MAX_W'(1) << (in_w - 1)));
    widen    = in_c << ext;
    if (mode == FILL_SIGN && sign) widen = widen | low_mask;
    if (mode == FILL_MUTE) widen = '0;
  endfunction

endpackage

// File: rtl/audio_rx_sync_fall.sv
// Three-flop synchronizer for the transmitter ready line with falling-edge
// detect; flops reset high so releasing reset never looks like an edge.
module audio_rx_sync_fall (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[1:0], rx_i};
  end

  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/audio_rx_fifo.sv
// Multi-channel audio receiver: captures a frame on each rx_ready falling edge,
// widens samples and buffers frames in a show-ahead FIFO. Optional per-channel
// peak meter is enabled with `define AUDIO_RX_PEAK_EN.
module audio_rx_fifo
  import audio_rx_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 12,
  parameter int OUT_W  = 18,
  parameter int DEPTH  = 8
) (
  input  logic                      clock_in,
  input  logic                      reset,
  input  logic                      rx_ready,
  input  logic [NUM_CH*IN_W-1:0]    audio_in,
  input  logic [1:0]                fill_mode,
  input  logic                      out_ready,
  input  logic                      ovf_clear,
  output logic [NUM_CH*OUT_W-1:0]   audio_out,
  output logic                      out_valid,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
`ifdef AUDIO_RX_PEAK_EN
  ,
  input  logic                      peak_clear,
  output logic [NUM_CH*IN_W-1:0]    peak
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int FRM_W  = NUM_CH * OUT_W;

  logic [FRM_W-1:0] mem_q [DEPTH];
  logic [FRM_W-1:0] wdata, audio_out_q, audio_out_d;
  logic [LVL_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d, wr_ptr_d, level_w;
  logic             fall, full, pop, wr_en, ovf_set, overflow_q;

  audio_rx_sync_fall u_sync (
    .clk_i  (clock_in),
    .rst_ni (reset),
    .rx_i   (rx_ready),
    .fall_o (fall)
  );

  assign level_w   = wr_ptr_q - rd_ptr_q;
  assign out_valid = (level_w != '0);
  assign full      = (level_w == LVL_W'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign wr_en     = fall & (~full | pop);
  assign ovf_set   = fall & full & ~pop;

  always_comb begin
    wdata = '0;
    for (int c = 0; c < NUM_CH; c++)
      wdata[c*OUT_W +: OUT_W] =
        OUT_W'(widen(MAX_W'(audio_in[c*IN_W +: IN_W]), fill_mode, IN_W, OUT_W));
  end

  // Next head: the just-written frame bypasses storage when it lands at the new read slot.
  always_comb begin
    rd_ptr_d    = rd_ptr_q + LVL_W'(pop);
    wr_ptr_d    = wr_ptr_q + LVL_W'(wr_en);
    audio_out_d = audio_out_q;
    if (wr_ptr_d != rd_ptr_d)
      audio_out_d = (wr_en && wr_ptr_q == rd_ptr_d) ? wdata : mem_q[rd_ptr_d[ADDR_W-1:0]];
  end

  always_ff @(posedge clock_in) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      audio_out_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      audio_out_q <= audio_out_d;
      if (ovf_set)        overflow_q <= 1'b1;
      else if (ovf_clear) overflow_q <= 1'b0;
    end
  end

  assign audio_out = audio_out_q;
  assign level     = level_w;
  assign overflow  = overflow_q;

`ifdef AUDIO_RX_PEAK_EN
  localparam logic [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] MOST_POS = {1'b0, {(IN_W-1){1'b1}}};

  logic [NUM_CH*IN_W-1:0] peak_q, peak_d, mag;

  // Two's complement magnitude; the most negative code saturates to max positive.
  always_comb begin
    mag    = '0;
    peak_d = peak_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!audio_in[c*IN_W + IN_W - 1])
        mag[c*IN_W +: IN_W] = audio_in[c*IN_W +: IN_W];
      else if (audio_in[c*IN_W +: IN_W] == MOST_NEG)
        mag[c*IN_W +: IN_W] = MOST_POS;
      else
        mag[c*IN_W +: IN_W] = -audio_in[c*IN_W +: IN_W];

      if (peak_clear)
        peak_d[c*IN_W +: IN_W] = wr_en ? mag[c*IN_W +: IN_W] : '0;
      else if (wr_en && mag[c*IN_W +: IN_W] > peak_q[c*IN_W +: IN_W])
        peak_d[c*IN_W +: IN_W] = mag[c*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_audio_rx_fifo.sv
// Directed self-checking bench for audio_rx_fifo (default parameters); the peak
// section runs only when AUDIO_RX_PEAK_EN is defined.
module tb_audio_rx_fifo;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        rx_ready;
  logic [23:0] audio_in;
  logic [1:0]  fill_mode;
  logic        out_ready;
  logic        ovf_clear;
  logic [35:0] audio_out;
  logic        out_valid;
  logic [3:0]  level;
  logic        overflow;
`ifdef AUDIO_RX_PEAK_EN
  logic        peak_clear;
  logic [23:0] peak;
`endif

  int vectors    = 0;
  int miscompares = 0;

  audio_rx_fifo dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .rx_ready  (rx_ready),
    .audio_in  (audio_in),
    .fill_mode (fill_mode),
    .out_ready (out_ready),
    .ovf_clear (ovf_clear),
    .audio_out (audio_out),
    .out_valid (out_valid),
    .level     (level),
    .overflow  (overflow)
`ifdef AUDIO_RX_PEAK_EN
    ,
    .peak_clear(peak_clear),
    .peak      (peak)
`endif
  );

  always #5 clock_in = ~clock_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Full rx_ready pulse: write lands on the third edge; popAtWrite raises
  // out_ready for exactly that edge.
  task automatic applyStimulus(input logic [23:0] data, input logic [1:0] mode,
                               input bit popAtWrite);
    audio_in  = data;
    fill_mode = mode;
    rx_ready  = 1'b0;
    tick();
    tick();
    if (popAtWrite) out_ready = 1'b1;
    tick();
    if (popAtWrite) out_ready = 1'b0;
    tick();
    rx_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [23:0] frameIn(input int k);
    logic [11:0] a, b;
    a = 12'(k);
    b = 12'(k + 16);
    return {a, b};
  endfunction

  // Zero-fill expectation: each 12-bit sample shifted into the top of 18 bits.
  function automatic logic [35:0] frameZero(input int k);
    logic [11:0] a, b;
    a = 12'(k);
    b = 12'(k + 16);
    return {a, 6'b0, b, 6'b0};
  endfunction

  task automatic pulseReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    rx_ready   = 1'b1;
    audio_in   = '0;
    fill_mode  = 2'b00;
    out_ready  = 1'b0;
    ovf_clear  = 1'b0;
`ifdef AUDIO_RX_PEAK_EN
    peak_clear = 1'b0;
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset level", level, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset audio_out", audio_out, 0);
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("idle after release", level, 0);

    // Sign-replicate frame with latency checks
    audio_in  = {12'h800, 12'h7FF};
    fill_mode = 2'b01;
    rx_ready  = 1'b0;
    tick();
    checkOutput("latency edge1", out_valid, 0);
    tick();
    checkOutput("latency edge2", out_valid, 0);
    tick();
    checkOutput("latency edge3 valid", out_valid, 1);
    checkOutput("sign audio_out", audio_out, {18'h2003F, 18'h1FFC0});
    checkOutput("sign level", level, 1);
    tick();
    rx_ready = 1'b1;
    repeat (4) tick();
    fill_mode = 2'b10;
    tick();
    checkOutput("mode change no effect", audio_out, {18'h2003F, 18'h1FFC0});
    popOne();
    checkOutput("after pop valid", out_valid, 0);
    checkOutput("after pop level", level, 0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    checkOutput("empty hold audio_out", audio_out, {18'h2003F, 18'h1FFC0});
    checkOutput("empty hold level", level, 0);

    applyStimulus({12'h800, 12'h7FF}, 2'b00, 1'b0);
    checkOutput("zero audio_out", audio_out, {18'h20000, 18'h1FFC0});
    popOne();
    applyStimulus({12'h800, 12'h7FF}, 2'b10, 1'b0);
    checkOutput("mute audio_out", audio_out, 0);
    checkOutput("mute valid", out_valid, 1);
    popOne();
    applyStimulus({12'h800, 12'h7FF}, 2'b11, 1'b0);
    checkOutput("mode11 audio_out", audio_out, {18'h20000, 18'h1FFC0});
    popOne();
    checkOutput("modes drained", level, 0);

    // Overflow: nine frames into eight slots
    for (int k = 1; k <= 9; k++) applyStimulus(frameIn(k), 2'b00, 1'b0);
    checkOutput("full level", level, 8);
    checkOutput("overflow set", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      checkOutput("drain valid", out_valid, 1);
      checkOutput("drain data", audio_out, frameZero(k));
      popOne();
    end
    checkOutput("drained valid", out_valid, 0);
    checkOutput("drained level", level, 0);
    checkOutput("overflow sticky", overflow, 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checkOutput("overflow cleared", overflow, 0);

    // Full with write coinciding with a pop
    for (int k = 'h21; k <= 'h28; k++) applyStimulus(frameIn(k), 2'b00, 1'b0);
    checkOutput("refill level", level, 8);
    applyStimulus(frameIn('h29), 2'b00, 1'b1);
    checkOutput("write+pop overflow", overflow, 0);
    checkOutput("write+pop level", level, 8);
    for (int k = 'h22; k <= 'h29; k++) begin
      checkOutput("write+pop data", audio_out, frameZero(k));
      popOne();
    end
    checkOutput("write+pop drained", level, 0);

    // Asynchronous reset mid-stream
    for (int k = 'h31; k <= 'h35; k++) applyStimulus(frameIn(k), 2'b00, 1'b0);
    checkOutput("pre-reset level", level, 5);
    #3 reset = 1'b0;
    #1;
    checkOutput("async reset valid", out_valid, 0);
    checkOutput("async reset level", level, 0);
    checkOutput("async reset audio_out", audio_out, 0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    checkOutput("no spurious write level", level, 0);
    checkOutput("no spurious write valid", out_valid, 0);
    applyStimulus(frameIn('h40), 2'b00, 1'b0);
    checkOutput("post-reset level", level, 1);
    checkOutput("post-reset data", audio_out, frameZero('h40));

`ifdef AUDIO_RX_PEAK_EN
    pulseReset();
    checkOutput("peak reset", peak, 0);
    applyStimulus({12'h000, 12'h005}, 2'b00, 1'b0);
    checkOutput("peak 005", peak, {12'h000, 12'h005});
    applyStimulus({12'h000, 12'hFF0}, 2'b00, 1'b0);
    checkOutput("peak FF0", peak, {12'h000, 12'h010});
    applyStimulus({12'h000, 12'h800}, 2'b00, 1'b0);
    checkOutput("peak 800", peak, {12'h000, 12'h7FF});
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    checkOutput("peak cleared", peak, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
